// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the FP32 dot-product accumulator.
// fp_unpack flushes subnormals to zero and widens the mantissa with hidden bit plus G/R/S.
package fp_acc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP_ZERO    = 32'h00000000;
    localparam int          EXP_BIAS   = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] mant;
        logic        is_nan;
        logic        is_inf;
        logic        is_zero;
    } fp_unpacked_t;

    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        u.is_zero = (x[30:23] == 8'h00);
        u.mant    = u.is_zero ? 27'd0 : {1'b1, x[22:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/fp_acc_lzc.sv
// Combinational leading-zero counter used to normalise the post-add mantissa.
// An all-zero input reports W.
module fp_lzc #(
    parameter int W     = 27,
    parameter int CNT_W = 5
) (
    input  logic [W-1:0]     value_i,
    output logic [CNT_W-1:0] count_o
);

    logic found;

    always_comb begin
        count_o = CNT_W'(W);
        found   = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && value_i[i]) begin
                count_o = CNT_W'(W - 1 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_accum.sv
// Iterative FP32 accumulator: one operand at a time through ALIGN/ADD/NORM,
// result presented in DONE until the consumer takes it.
module fp_accum #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int RNE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        clear,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);
    import fp_acc_pkg::*;

    localparam int MANT_W = FRAC_W + 4;
    localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W + 2)'(1);
    localparam logic signed [EXP_W+1:0] EXP_INF = (EXP_W + 2)'(2 * EXP_BIAS + 1);

    state_t              stateQ, stateD;
    logic [31:0]         accQ, opQ, specialValQ;
    logic                lastQ, signAQ, signBQ, specialQ;
    logic [EXP_W-1:0]    expQ;
    logic [MANT_W-1:0]   mantAQ, mantBQ;
    logic [MANT_W:0]     sumQ;

    assign in_ready  = (stateQ == IDLE);
    assign out_valid = (stateQ == DONE);
    assign out_data  = out_valid ? accQ : FP_ZERO;

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (in_valid) stateD = ALIGN;
            ALIGN:   stateD = ADD;
            ADD:     stateD = NORM;
            NORM:    stateD = lastQ ? DONE : IDLE;
            DONE:    if (out_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    fp_unpacked_t      accU, opU;
    logic              bigSign, smallSign, smallZero;
    logic [EXP_W-1:0]  bigExp, smallExp, expDiff;
    logic [MANT_W-1:0] bigMant, smallMant, shiftedB, lostMask, alignedB;
    logic              specialD;
    logic [31:0]       specialValD;

    // Larger magnitude becomes operand A so the subtract in ADD never goes negative.
    always_comb begin
        accU = fp_unpack(accQ);
        opU  = fp_unpack(opQ);
        if ({opU.exp, opU.mant} > {accU.exp, accU.mant}) begin
            bigSign = opU.sign;   bigExp = opU.exp;   bigMant = opU.mant;
            smallSign = accU.sign; smallExp = accU.exp; smallMant = accU.mant;
            smallZero = accU.is_zero;
        end else begin
            bigSign = accU.sign;  bigExp = accU.exp;  bigMant = accU.mant;
            smallSign = opU.sign; smallExp = opU.exp; smallMant = opU.mant;
            smallZero = opU.is_zero;
        end
        expDiff  = bigExp - smallExp;
        shiftedB = smallMant >> expDiff[4:0];
        lostMask = (MANT_W'(1) << expDiff[4:0]) - MANT_W'(1);
        if (smallZero)
            alignedB = '0;
        else if (expDiff >= EXP_W'(26))
            alignedB = MANT_W'(1);
        else
            alignedB = shiftedB | MANT_W'(|(smallMant & lostMask));

        specialD    = 1'b1;
        specialValD = FP_QNAN;
        if (accU.is_nan || opU.is_nan || (accU.is_inf && opU.is_inf && (accU.sign != opU.sign)))
            specialValD = FP_QNAN;
        else if (accU.is_inf)
            specialValD = accQ;
        else if (opU.is_inf)
            specialValD = opQ;
        else
            specialD = 1'b0;
    end

    logic [4:0]               lzCount;
    logic signed [EXP_W+1:0]  expN, expR;
    logic [MANT_W-1:0]        mantN;
    logic                     roundUp;
    logic [FRAC_W+1:0]        mantR;
    logic [FRAC_W-1:0]        fracR;
    logic [31:0]              normResult;

    fp_lzc #(.W(MANT_W), .CNT_W(5)) uLzc (
        .value_i (sumQ[MANT_W-1:0]),
        .count_o (lzCount)
    );

    // Carry-out keeps the shifted-off bit as sticky; rounding carry renormalises via mantR's top bit.
    always_comb begin
        if (sumQ[MANT_W]) begin
            mantN = {sumQ[MANT_W:2], sumQ[1] | sumQ[0]};
            expN  = $signed({2'b00, expQ}) + EXP_ONE;
        end else begin
            mantN = sumQ[MANT_W-1:0] << lzCount;
            expN  = $signed({2'b00, expQ}) - $signed({{(EXP_W-3){1'b0}}, lzCount});
        end
        roundUp = (RNE != 0) && mantN[2] && (mantN[3] || mantN[1] || mantN[0]);
        mantR   = {1'b0, mantN[MANT_W-1:3]} + {{(FRAC_W+1){1'b0}}, roundUp};
        if (mantR[FRAC_W+1]) begin
            fracR = mantR[FRAC_W:1];
            expR  = expN + EXP_ONE;
        end else begin
            fracR = mantR[FRAC_W-1:0];
            expR  = expN;
        end

        if (specialQ)
            normResult = specialValQ;
        else if ((sumQ == '0) || (expN < EXP_ONE))
            normResult = FP_ZERO;
        else if (expR >= EXP_INF)
            normResult = FP_POS_INF | {signAQ, 31'd0};
        else
            normResult = {signAQ, expR[EXP_W-1:0], fracR};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ      <= IDLE;
            accQ        <= FP_ZERO;
            opQ         <= '0;
            lastQ       <= 1'b0;
            signAQ      <= 1'b0;
            signBQ      <= 1'b0;
            expQ        <= '0;
            mantAQ      <= '0;
            mantBQ      <= '0;
            sumQ        <= '0;
            specialQ    <= 1'b0;
            specialValQ <= '0;
        end else begin
            stateQ <= stateD;
            case (stateQ)
                IDLE: begin
                    if (clear) accQ <= FP_ZERO;
                    if (in_valid) begin
                        opQ   <= in_data;
                        lastQ <= in_last;
                    end
                end
                ALIGN: begin
                    signAQ      <= bigSign;
                    signBQ      <= smallSign;
                    expQ        <= bigExp;
                    mantAQ      <= bigMant;
                    mantBQ      <= alignedB;
                    specialQ    <= specialD;
                    specialValQ <= specialValD;
                end
                ADD: begin
                    if (signAQ != signBQ)
                        sumQ <= {1'b0, mantAQ} - {1'b0, mantBQ};
                    else
                        sumQ <= {1'b0, mantAQ} + {1'b0, mantBQ};
                end
                NORM: accQ <= normResult;
                DONE: if (out_ready) accQ <= FP_ZERO;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Randomised and directed bench for fp_accum; two instances cover RNE=1 and RNE=0.
// Expected sums come from an exact big-integer add followed by a single rounding step.
module tb_fp_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, clear, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic        inReadyT, outValidT;
    logic [31:0] outDataT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] refAcc, refAccT;

    always #5 clk = ~clk;

    fp_accum #(.RNE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    fp_accum #(.RNE(0)) dutTrunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyT),
        .in_data(in_data), .in_last(in_last), .clear(clear),
        .out_valid(outValidT), .out_ready(out_ready), .out_data(outDataT)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Exact sum as a wide integer scaled by 2^149, then rounded once to 24 bits.
    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b, input bit rne);
        logic [299:0] magA, magB, mag, kept, rem, half;
        int  ea, eb, p, e, sh;
        bit  sign, up, aNan, bNan, aInf, bInf;
        aNan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bNan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        aInf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bInf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (aNan || bNan || (aInf && bInf && (a[31] != b[31]))) return 32'h7FC00000;
        if (aInf) return a;
        if (bInf) return b;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        magA = (ea == 0) ? '0 : (300'({1'b1, a[22:0]}) << (ea - 1));
        magB = (eb == 0) ? '0 : (300'({1'b1, b[22:0]}) << (eb - 1));
        if (a[31] == b[31]) begin
            mag = magA + magB; sign = a[31];
        end else if (magA >= magB) begin
            mag = magA - magB; sign = a[31];
        end else begin
            mag = magB - magA; sign = b[31];
        end
        if (mag == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e < 1) return 32'h0;
        sh   = p - 23;
        kept = mag >> sh;
        rem  = mag - (kept << sh);
        half = (sh > 0) ? (300'(1) << (sh - 1)) : '0;
        up   = rne && (sh > 0) && ((rem > half) || ((rem == half) && kept[0]));
        kept = kept + 300'(up);
        if (kept[24]) begin
            kept = kept >> 1;
            e++;
        end
        if (e >= 255) return {sign, 8'hFF, 23'd0};
        return {sign, 8'(e), kept[22:0]};
    endfunction

    function automatic logic [31:0] randOperand();
        logic        s;
        logic [22:0] f;
        int          k;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        k = $urandom_range(0, 31);
        case (k)
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, f | 23'd1};
            3:       return {s, 8'h00, f | 23'd1};
            4:       return {s, 8'(253 + $urandom_range(0, 1)), f};
            default: return {s, 8'($urandom_range(112, 142)), f};
        endcase
    endfunction

    task automatic waitReady();
        int cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Returns #1 after the accepting edge; optionally checks the 3-cycle busy window.
    task automatic applyStimulus(input logic [31:0] data, input bit last, input bit clr, input bit chkTiming);
        waitReady();
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        clear    = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear    = 1'b0;
        if (clr) begin
            refAcc  = 32'h0;
            refAccT = 32'h0;
        end
        refAcc  = refAdd(refAcc, data, 1'b1);
        refAccT = refAdd(refAccT, data, 1'b0);
        if (chkTiming) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("busy_ready%0d", i), 32'(in_ready), 32'd0);
                checkOutput($sformatf("busy_valid%0d", i), 32'(out_valid), 32'd0);
                @(posedge clk); #1;
            end
            if (last) checkOutput("latency_valid", 32'(out_valid), 32'd1);
            else      checkOutput("latency_ready", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic collectResult(input string tag, input logic [31:0] expR, input logic [31:0] expT, input int hold);
        int cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_validTrunc"}, 32'(outValidT), 32'd1);
        checkOutput({tag, "_data"}, out_data, expR);
        checkOutput({tag, "_dataTrunc"}, outDataT, expT);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_holdValid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_holdData"}, out_data, expR);
            checkOutput({tag, "_holdReady"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_released"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(in_ready), 32'd1);
        refAcc  = 32'h0;
        refAccT = 32'h0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] op;
        bit clr;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear = 1'b0; out_ready = 1'b0;
        refAcc = 32'h0; refAccT = 32'h0;

        // Offer an operand while in reset: it must not be taken.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", out_data, 32'h0);
        in_valid = 1'b1; in_data = 32'h40000000; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_noTransfer", 32'(in_ready), 32'd1);

        applyStimulus(32'h40800000, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h41800000, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h42800000, 1'b1, 1'b0, 1'b1);
        collectResult("sum84", 32'h42A80000, 32'h42A80000, 0);

        applyStimulus(32'h40400000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'hC0400000, 1'b1, 1'b0, 1'b0);
        collectResult("cancel", 32'h00000000, 32'h00000000, 0);

        applyStimulus(32'h7F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'hFF800000, 1'b1, 1'b0, 1'b0);
        collectResult("infMinusInf", 32'h7FC00000, 32'h7FC00000, 0);

        applyStimulus(32'h7F7FFFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h7F7FFFFF, 1'b1, 1'b0, 1'b0);
        collectResult("overflow", 32'h7F800000, 32'h7F800000, 0);

        applyStimulus(32'h3F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h33800000, 1'b1, 1'b0, 1'b0);
        collectResult("tieEven", 32'h3F800000, 32'h3F800000, 0);

        applyStimulus(32'h3F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h33C00000, 1'b1, 1'b0, 1'b0);
        collectResult("roundUp", 32'h3F800001, 32'h3F800000, 0);

        applyStimulus(32'h40000000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h40400000, 1'b1, 1'b0, 1'b0);
        collectResult("backpressure", 32'h40A00000, 32'h40A00000, 5);
        applyStimulus(32'h3F800000, 1'b1, 1'b0, 1'b0);
        collectResult("afterDone", 32'h3F800000, 32'h3F800000, 0);

        applyStimulus(32'h40000000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h40400000, 1'b1, 1'b1, 1'b0);
        collectResult("clearWithOp", 32'h40400000, 32'h40400000, 0);

        applyStimulus(32'h40000000, 1'b0, 1'b0, 1'b0);
        waitReady();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        refAcc = 32'h0; refAccT = 32'h0;
        applyStimulus(32'h3F800000, 1'b1, 1'b0, 1'b0);
        collectResult("clearAlone", 32'h3F800000, 32'h3F800000, 0);

        applyStimulus(32'h40000000, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        applyStimulus(32'h40000000, 1'b1, 1'b0, 1'b0);
        collectResult("clearIgnored", 32'h40800000, 32'h40800000, 0);

        // Reset while the operand sits in ADD.
        applyStimulus(32'h41200000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("rstAdd_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        refAcc = 32'h0; refAccT = 32'h0;
        @(posedge clk); #1;
        checkOutput("rstAdd_ready", 32'(in_ready), 32'd1);
        applyStimulus(32'h40000000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h40400000, 1'b1, 1'b0, 1'b0);
        collectResult("afterRstAdd", 32'h40A00000, 32'h40A00000, 0);

        // Reset while a result is pending in DONE.
        applyStimulus(32'h40000000, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rstDone_valid", 32'(out_valid), 32'd0);
        checkOutput("rstDone_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        refAcc = 32'h0; refAccT = 32'h0;
        applyStimulus(32'h3F800000, 1'b1, 1'b0, 1'b0);
        collectResult("afterRstDone", 32'h3F800000, 32'h3F800000, 0);

        for (int s = 0; s < 30; s++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                op  = randOperand();
                clr = (k == 0) && ($urandom_range(0, 7) == 0);
                applyStimulus(op, k == n - 1, clr, 1'b0);
            end
            collectResult($sformatf("rand%0d", s), refAcc, refAccT, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
